// File: rtl/ysyx_23060208_clint_pkg.sv
// Shared constants, FSM state types and address/strobe helpers for the CLINT.
// Build option YSYX_23060208_CLINT_WRITE_EN adds the byte-strobe merge helper.
package ysyx_23060208_clint_pkg;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'h0000_FFFF;
  localparam logic [15:0] MTIME_OFF  = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;

  // Only the 8-byte slot inside the 64 KiB window decides a hit.
  function automatic logic mtime_hit(input logic [31:0] addr);
    return ((addr & CLINT_MASK) >> 3) == {19'd0, MTIME_OFF[15:3]};
  endfunction

`ifdef YSYX_23060208_CLINT_WRITE_EN
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction
`endif

endpackage

// File: rtl/ysyx_23060208_clint_mtime.sv
// Prescaled 64-bit mtime counter; with YSYX_23060208_CLINT_WRITE_EN it also
// takes a byte-strobed write port that overrides the tick in the same cycle.
module ysyx_23060208_clint_mtime
  import ysyx_23060208_clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef YSYX_23060208_CLINT_WRITE_EN
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
`endif
  output logic [63:0] mtime_o
);

  localparam logic [31:0] PRE_LAST = 32'(TICK_DIV - 1);

  logic [31:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick_s;

  assign tick_s = (pre_q == PRE_LAST);

  // Next prescaler and counter value; a write takes priority over a tick.
  always_comb begin
    pre_d   = tick_s ? 32'd0 : pre_q + 32'd1;
    mtime_d = mtime_q;
`ifdef YSYX_23060208_CLINT_WRITE_EN
    if (we_i) begin
      mtime_d = strb_merge(mtime_q, wdata_i, wstrb_i);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
`else
    if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
`endif
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= 32'd0;
      mtime_q <= 64'd0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/ysyx_23060208_clint.sv
// AXI4 responder for the CLINT window: burst reads return an mtime snapshot.
// Define YSYX_23060208_CLINT_WRITE_EN to accept single-beat writes to mtime.
module ysyx_23060208_clint
  import ysyx_23060208_clint_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic                      arready,
  input  logic                      arvalid,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [3:0]                arid,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      rready,
  output logic                      rvalid,
  output logic [1:0]                rresp,
  output logic [DATA_WIDTH*2-1:0]   rdata,
  output logic                      rlast,
  output logic [3:0]                rid,
  output logic                      awready,
  input  logic                      awvalid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [3:0]                awid,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  output logic                      wready,
  input  logic                      wvalid,
  input  logic [DATA_WIDTH*2-1:0]   wdata,
  input  logic [DATA_WIDTH/4-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      bready,
  output logic                      bvalid,
  output logic [1:0]                bresp,
  output logic [3:0]                bid,
  output logic [63:0]               mtime
);

  logic [63:0] mtime_s;

  rstate_e               rstate_q, rstate_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d, rburst_q, rburst_d;
  logic [63:0]           rdata_q, rdata_d, snap_q, snap_d;
  logic [3:0]            rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt_s;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic                  ar_hs_s;

  wstate_e    wstate_q, wstate_d;
  logic       awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [3:0] awid_q, awid_d, bid_q, bid_d;
  logic [1:0] bresp_q, bresp_d;
  logic       aw_hs_s, w_hs_s, commit_s, wr_ok_s;
  logic       unused_s;

  assign ar_hs_s  = arready_q & arvalid;
  assign aw_hs_s  = awready_q & awvalid;
  assign w_hs_s   = wready_q & wvalid;
  assign commit_s = (wstate_q == W_IDLE) & (aw_done_q | aw_hs_s) & (w_done_q | (w_hs_s & wlast));

  // Address of the following read beat; WRAP bursts walk like INCR.
  always_comb begin
    case (rburst_q)
      BURST_FIXED:            raddr_nxt_s = raddr_q;
      BURST_INCR, BURST_WRAP: raddr_nxt_s = raddr_q + ADDR_WIDTH'(8);
      default:                raddr_nxt_s = raddr_q + ADDR_WIDTH'(8);
    endcase
  end

  // Read FSM: the snapshot is taken on the AR handshake and served on every hit beat.
  always_comb begin
    rstate_d = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rresp_d = rresp_q; rdata_d = rdata_q; rid_d = rid_q; raddr_d = raddr_q;
    rlen_d = rlen_q; rbeat_d = rbeat_q; rburst_d = rburst_q; snap_d = snap_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = arid;
          rlen_d    = arlen;
          rbeat_d   = 8'd0;
          raddr_d   = araddr;
          rburst_d  = arburst;
          snap_d    = mtime_s;
          rlast_d   = (arlen == 8'd0);
          rdata_d   = mtime_hit(araddr) ? mtime_s : 64'd0;
          rresp_d   = mtime_hit(araddr) ? RESP_OKAY : RESP_DECERR;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rready && rlast_q) begin
          rstate_d  = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rdata_d   = 64'd0;
          rresp_d   = RESP_OKAY;
          rid_d     = 4'd0;
        end else if (rready) begin
          raddr_d = raddr_nxt_s;
          rbeat_d = rbeat_q + 8'd1;
          rlast_d = ((rbeat_q + 8'd1) == rlen_q);
          rdata_d = mtime_hit(raddr_nxt_s) ? snap_q : 64'd0;
          rresp_d = mtime_hit(raddr_nxt_s) ? RESP_OKAY : RESP_DECERR;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Write FSM: AW and the wlast beat are captured independently, then one B response.
  always_comb begin
    wstate_d = wstate_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    aw_done_d = aw_done_q; w_done_d = w_done_q; awid_d = awid_q; bid_d = bid_q; bresp_d = bresp_q;
    case (wstate_q)
      W_IDLE: begin
        if (commit_s) begin
          wstate_d  = W_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bvalid_d  = 1'b1;
          bid_d     = aw_done_q ? awid_q : awid;
          bresp_d   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_hs_s) begin
            aw_done_d = 1'b1;
            awready_d = 1'b0;
            awid_d    = awid;
          end else begin
            awready_d = ~aw_done_q;
          end
          if (w_hs_s && wlast) begin
            w_done_d = 1'b1;
            wready_d = 1'b0;
          end else begin
            wready_d = ~w_done_q;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          wstate_d  = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          bid_d     = 4'd0;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: begin
        wstate_d = W_IDLE;
        bvalid_d = 1'b0;
      end
    endcase
  end

  // Read and write FSM state plus all registered AXI outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstate_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rresp_q <= 2'b00; rdata_q <= 64'd0; rid_q <= 4'd0; raddr_q <= '0;
      rlen_q <= 8'd0; rbeat_q <= 8'd0; rburst_q <= 2'b00; snap_q <= 64'd0;
      wstate_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      aw_done_q <= 1'b0; w_done_q <= 1'b0; awid_q <= 4'd0; bid_q <= 4'd0; bresp_q <= 2'b00;
    end else begin
      rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rresp_q <= rresp_d; rdata_q <= rdata_d; rid_q <= rid_d; raddr_q <= raddr_d;
      rlen_q <= rlen_d; rbeat_q <= rbeat_d; rburst_q <= rburst_d; snap_q <= snap_d;
      wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      aw_done_q <= aw_done_d; w_done_q <= w_done_d; awid_q <= awid_d; bid_q <= bid_d; bresp_q <= bresp_d;
    end
  end

`ifdef YSYX_23060208_CLINT_WRITE_EN
  logic [ADDR_WIDTH-1:0]   awaddr_q, c_addr_s;
  logic [7:0]              awlen_q, c_len_s;
  logic [DATA_WIDTH*2-1:0] wdata_q, c_data_s;
  logic [DATA_WIDTH/4-1:0] wstrb_q, c_strb_s;
  logic                    we_s;

  // Hold the AW/W payload when one channel arrives ahead of the other.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      awaddr_q <= '0; awlen_q <= 8'd0; wdata_q <= '0; wstrb_q <= '0;
    end else begin
      if (aw_hs_s) begin
        awaddr_q <= awaddr;
        awlen_q  <= awlen;
      end
      if (w_hs_s && wlast) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  assign c_addr_s = aw_done_q ? awaddr_q : awaddr;
  assign c_len_s  = aw_done_q ? awlen_q : awlen;
  assign c_data_s = w_done_q ? wdata_q : wdata;
  assign c_strb_s = w_done_q ? wstrb_q : wstrb;
  assign wr_ok_s  = mtime_hit(c_addr_s) & (c_len_s == 8'd0);
  assign we_s     = commit_s & wr_ok_s;
  assign unused_s = ^{arsize, awsize, awburst, CLINT_BASE};
`else
  assign wr_ok_s  = 1'b0;
  assign unused_s = ^{arsize, awsize, awburst, awaddr, awlen, wdata, wstrb, CLINT_BASE};
`endif

  ysyx_23060208_clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clk_i   (clock),
    .rst_ni  (reset),
`ifdef YSYX_23060208_CLINT_WRITE_EN
    .we_i    (we_s),
    .wdata_i (c_data_s),
    .wstrb_i (c_strb_s),
`endif
    .mtime_o (mtime_s)
  );

  assign mtime   = mtime_s;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Scoreboard bench for ysyx_23060208_clint: directed reads and writes, with a
// reference mtime that counts every clock and follows committed writes.
`timescale 1ns/1ps
module tb_ysyx_23060208_clint;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arready, arvalid, rready, rvalid, rlast, awready, awvalid, wready, wvalid, wlast;
  logic        bready, bvalid;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, rid, awid, bid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [63:0] rdata, wdata, mtime;

  ysyx_23060208_clint dut (
    .clock(clock), .reset(reset),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid),
    .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
    .mtime(mtime)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
  typedef struct packed { logic [1:0] resp; logic [3:0] id; } bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];
  int     total = 0;
  int     bad   = 0;

  logic        ref_we   = 1'b0;
  logic [63:0] ref_wval = 64'd0;
  logic [63:0] ref_mtime;

  // Reference counter: one tick per clock, a committed write replaces it.
  always @(posedge clock or negedge reset) begin
    if (!reset)      ref_mtime <= 64'd0;
    else if (ref_we) ref_mtime <= ref_wval;
    else             ref_mtime <= ref_mtime + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
    rbeat_t e;
    e.data = d; e.resp = resp; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
    bexp_t e;
    e.resp = resp; e.id = id;
    bq.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every R/B handshake and tracks mtime each cycle.
  always @(negedge clock) begin
    rbeat_t re;
    bexp_t  be;
    chk("mtime_track", mtime, ref_mtime);
    if (reset && rvalid && rready) begin
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL r_extra: got beat id %0h data %h, expected no beat", rid, rdata);
      end else begin
        re = rq.pop_front();
        chk("rdata", rdata, re.data);
        chk("rresp", 64'(rresp), 64'(re.resp));
        chk("rlast", 64'(rlast), 64'(re.last));
        chk("rid",   64'(rid),   64'(re.id));
      end
    end
    if (reset && bvalid && bready) begin
      if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra: got response id %0h, expected none", bid);
      end else begin
        be = bq.pop_front();
        chk("bresp", 64'(bresp), 64'(be.resp));
        chk("bid",   64'(bid),   64'(be.id));
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (rq.size() == 0 && bq.size() == 0) break;
      @(posedge clock); #1;
    end
    total++;
    if (rq.size() != 0 || bq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d beats and %0d responses pending, expected 0", name, rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
  endtask

  // Called #1 after a clock edge with the read FSM idle; returns after the AR handshake.
  task automatic issue_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] burst, output logic [63:0] snap);
    chk("arready_idle", 64'(arready), 64'd1);
    snap = ref_mtime;
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id; arsize = 3'd3; arburst = burst;
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  // AW and the first W beat are offered together; later beats follow one per cycle.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [63:0] data, input logic [7:0] strb, input logic [1:0] resp,
                          input logic commit, input logic [63:0] wval);
    chk("awready_idle", 64'(awready), 64'd1);
    chk("wready_idle",  64'(wready),  64'd1);
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id; awsize = 3'd3; awburst = 2'b01;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = (len == 8'd0);
    ref_we = commit && (len == 8'd0);
    ref_wval = wval;
    push_b(resp, id);
    @(posedge clock); #1;
    awvalid = 1'b0;
    ref_we = 1'b0;
    for (int b = 1; b <= int'(len); b++) begin
      wlast = (b == int'(len));
      wdata = ~data;
      @(posedge clock); #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  initial begin
    logic [63:0] snap;
    logic [63:0] wv;
    arvalid = 1'b0; araddr = 32'd0; arid = 4'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
    rready = 1'b1; bready = 1'b1;
    awvalid = 1'b0; awaddr = 32'd0; awid = 4'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
    wvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0;

    // Reset state, then 100 idle cycles.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_mtime",   mtime, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("arready_first", 64'(arready), 64'd1);
    chk("awready_first", 64'(awready), 64'd1);
    chk("wready_first",  64'(wready),  64'd1);
    chk("mtime_first",   mtime, 64'd1);
    repeat (99) @(posedge clock);
    #1;
    chk("mtime_100", mtime, 64'd100);

    // Fresh reset, single read snapshotted at mtime 0x50 with rready stalled.
    #2 reset = 1'b0;
    #1 chk("async_rst_mtime", mtime, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 200 && ref_mtime != 64'h50; i++) begin
      @(posedge clock); #1;
    end
    rready = 1'b0;
    issue_read(32'h0200_BFF8, 8'd0, 4'h5, 2'b01, snap);
    push_r(64'h50, 2'b00, 1'b1, 4'h5);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rvalid", 64'(rvalid), 64'd1);
      chk("hold_rdata",  rdata, 64'h50);
      @(posedge clock); #1;
    end
    rready = 1'b1;
    wait_drain("single_read");

    // INCR burst from 0xBFF0: a miss beat, then the hit beat.
    issue_read(32'h0200_BFF0, 8'd1, 4'h3, 2'b01, snap);
    push_r(64'd0, 2'b11, 1'b0, 4'h3);
    push_r(snap,  2'b00, 1'b1, 4'h3);
    wait_drain("incr_burst");

    // FIXED burst on 0xBFF8: both beats hit with the same snapshot.
    issue_read(32'h0200_BFF8, 8'd1, 4'h9, 2'b00, snap);
    push_r(snap, 2'b00, 1'b0, 4'h9);
    push_r(snap, 2'b00, 1'b1, 4'h9);
    wait_drain("fixed_burst");

`ifdef YSYX_23060208_CLINT_WRITE_EN
    do_write(32'h0200_BFF8, 8'd0, 4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (2) @(posedge clock);
    #1 chk("wrap_to_zero", mtime, 64'd0);
    wait_drain("full_write");
    wv = {ref_mtime[63:32], 32'h0000_1234};
    do_write(32'h0200_BFF8, 8'd0, 4'h4, 64'hDEAD_BEEF_0000_1234, 8'h0F, 2'b00, 1'b1, wv);
    repeat (2) @(posedge clock);
    #1 chk("low_word_write", mtime, 64'h0000_0000_0000_1236);
    wait_drain("strb_write");
`else
    wv = 64'd0;
    do_write(32'h0200_BFF8, 8'd0, 4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 2'b10, 1'b0, wv);
    repeat (2) @(posedge clock);
    #1 chk("keeps_counting", mtime, ref_mtime);
    wait_drain("full_write");
    do_write(32'h0200_BFF8, 8'd0, 4'h4, 64'hDEAD_BEEF_0000_1234, 8'h0F, 2'b10, 1'b0, wv);
    wait_drain("strb_write");
`endif
    do_write(32'h0200_0000, 8'd0, 4'h6, 64'h1111_2222_3333_4444, 8'hFF, 2'b10, 1'b0, 64'd0);
    wait_drain("miss_write");
    do_write(32'h0200_BFF8, 8'd1, 4'hA, 64'h5555_6666_7777_8888, 8'hFF, 2'b10, 1'b0, 64'd0);
    wait_drain("multi_beat_write");

    // Reset while a beat waits on rready, then a clean read afterwards.
    rready = 1'b0;
    issue_read(32'h0200_BFF8, 8'd0, 4'h7, 2'b01, snap);
    chk("pre_abort_rvalid", 64'(rvalid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_rvalid", 64'(rvalid), 64'd0);
    chk("abort_rdata",  rdata, 64'd0);
    chk("abort_bvalid", 64'(bvalid), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    rready = 1'b1;
    @(posedge clock); #1;
    issue_read(32'h0200_BFF8, 8'd0, 4'h8, 2'b01, snap);
    push_r(snap, 2'b00, 1'b1, 4'h8);
    wait_drain("read_after_reset");

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_clint.md
# ysyx_23060208_clint

AXI4 responder for the core-local interruptor (CLINT) window 0x0200_0000–0x0200_FFFF; the interconnect's CLINT master port connects here. Holds the 64-bit free-running `mtime` counter and answers read bursts with a coherent snapshot of it. Optionally, when the build enables it, it also accepts writes to `mtime`; otherwise writes are answered with SLVERR.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, base width; the data bus is `DATA_WIDTH*2` = 64 bits
- `TICK_DIV`, 1, `mtime` increments once every `TICK_DIV` clocks (≥1)

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `arready` out 1 / `arvalid` in 1 / `araddr` in 32 / `arid` in 4 / `arlen` in 8 / `arsize` in 3 / `arburst` in 2  AR channel
- `rready` in 1 / `rvalid` out 1 / `rresp` out 2 / `rdata` out 64 / `rlast` out 1 / `rid` out 4  R channel
- `awready` out 1 / `awvalid` in 1 / `awaddr` in 32 / `awid` in 4 / `awlen` in 8 / `awsize` in 3 / `awburst` in 2  AW channel
- `wready` out 1 / `wvalid` in 1 / `wdata` in 64 / `wstrb` in 8 / `wlast` in 1  W channel
- `bready` in 1 / `bvalid` out 1 / `bresp` out 2 / `bid` out 4  B channel
- `mtime` out 64  live counter value, for the interrupt logic

## Operation
- Counter: 64-bit `mtime`, reset 0. A prescaler counts 0..`TICK_DIV`-1; `mtime` increments on the wrap. `mtime` wraps from 2^64-1 to 0.
- `mtime` lives at offset 0xBFF8. A beat hits when `addr[15:3]` == 0xBFF8>>3. The full 64-bit value is returned on every hit; lane selection is the master's job.
- Read FSM:
  - R_IDLE: `arready`=1. On an AR handshake, latch `arid` and `arlen`, latch the beat address, and take the snapshot `snap` = current `mtime`. Go to R_DATA.
  - R_DATA: `rvalid`=1.
    - Hit beat: `rdata`=`snap`, `rresp`=OKAY (00).
    - Miss beat: `rdata`=0, `rresp`=DECERR (11).
    - `rid` = latched id; `rlast`=1 on beat `arlen`.
    - On `rready`: advance the beat. For INCR, address += 8; for FIXED, the address is held. WRAP is treated as INCR.
    - After the last beat, return to R_IDLE.
- Write FSM:
  - W_IDLE: `awready`=`wready`=1. AW and W are captured independently; each ready drops once its channel is captured.
  - When AW and the `wlast` beat are both captured, go to W_RESP.
  - W_RESP: `bvalid`=1, `bid` = latched `awid`. Hold until `bready`, then return to W_IDLE.
  - Beats before `wlast` are accepted and discarded. Only the `wlast` beat can commit.
- Simultaneous events:
  - A write commit and a counter tick in the same cycle: the write wins; incrementing resumes from the written value the next tick.
  - An AR snapshot taken in the same cycle as a write commit captures the pre-write value.
  - Read and write FSMs run concurrently and independently.

## Timing
- While `reset` is low: every output is 0, including `arready`, `awready` and `wready`. Both FSMs are in IDLE, `mtime`=0, prescaler=0.
- Read latency: AR handshake in cycle N → first `rvalid` in N+1. One beat per cycle while `rready` is held high.
- R outputs hold stable while `rvalid`=1 && !`rready`.
- Write: final handshake in cycle N → `mtime` updated and `bvalid` asserted in N+1.
- Reset asserted mid-burst: the transfer is aborted immediately and `rvalid`/`bvalid` drop asynchronously. No completion after reset.
- `mtime` output is registered: it shows the post-increment value the cycle after the tick.

## Configuration
- `YSYX_23060208_CLINT_WRITE_EN` defined:
  - A single-beat write (`awlen`==0) hitting 0xBFF8 merges the `wdata` bytes selected by `wstrb` into `mtime`; `bresp`=OKAY.
  - A multi-beat write or a miss: no update, `bresp`=SLVERR (10).
- Not defined: every write completes with SLVERR and `mtime` is never modified. The write-merge logic is absent.

## Structure
- Package `ysyx_23060208_clint_pkg`:
  - `CLINT_BASE` = 32'h0200_0000, `CLINT_MASK`, `MTIME_OFF` = 16'hBFF8
  - AXI response codes OKAY/SLVERR/DECERR
  - burst codes
  - read FSM enum {R_IDLE, R_DATA} and write FSM enum {W_IDLE, W_RESP}
- Sub-module `ysyx_23060208_clint_mtime`: prescaler, 64-bit counter, and the strobe-merge write port (`we`, `wdata`, `wstrb`). The top level holds both AXI FSMs.

## Test plan
- Reset release, `TICK_DIV`=1, idle 100 cycles → `mtime`=100 (±1 for the sample edge); `arready`=1 from the first cycle after release.
- Single read of 0x0200_BFF8 issued at `mtime`=0x50 → one beat: `rdata`=0x50 (the snapshot), OKAY, `rlast`=1, `rid` echoed; `rready` held low 5 cycles → `rdata` unchanged.
- INCR burst, `arlen`=1, at 0x0200_BFF0 → beat 0 DECERR with data 0, beat 1 OKAY with the snapshot and `rlast`=1.
- With the macro, write 0xFFFF_FFFF_FFFF_FFFE with `wstrb`=0xFF → `bresp`=OKAY; two ticks later `mtime`=0 (wrap). Without the macro, the same write → SLVERR and `mtime` keeps counting.
- With the macro, `wstrb`=0x0F, `wdata` low word 0x1234 → only `mtime[31:0]` is replaced.
- Reset pulsed while R_DATA is waiting on `rready` → `rvalid`=0 immediately; after release, a new read completes normally.
